// File: rtl/sync_fifo_ex_if.sv
// rtl/sync_fifo_ex_if.sv - write/read handshake and status bundle for sync_fifo_ex
// The FIFO binds the slave modport, the producer/consumer side binds master.
interface sync_fifo_ex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  re;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;
  logic                  clear_err;

  modport slave (
    input  data_in, we, re, clear_err,
    output full, almost_full, data_out, empty, almost_empty, level, overflow, underflow
  );

  modport master (
    output data_in, we, re, clear_err,
    input  full, almost_full, data_out, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ex.sv
// rtl/sync_fifo_ex.sv - single-clock FIFO with level, thresholds, optional FWFT and sticky errors
// FWFT mode chains the registered RAM read into an output register so reads sustain one word per cycle.
module sync_fifo_ex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  sync_fifo_ex_if.slave fifo
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LV  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LV  = (ADDR_WIDTH + 1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LV = (ADDR_WIDTH + 1)'(AEMPTY_TH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

  if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_th_check
    $error("sync_fifo_ex: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ram_q_valid;
  logic                  out_valid;
  logic                  ovf_q;
  logic                  unf_q;

  logic ram_empty;
  logic ptr_full;
  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;
  logic ram_rd;
  logic out_load;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // In FWFT mode up to two words sit outside the RAM, so fullness follows the word count.
  assign full_w  = (FWFT != 0) ? (level_q == DEPTH_LV) : ptr_full;
  assign empty_w = (FWFT != 0) ? !out_valid : ram_empty;

  assign wr_acc = fifo.we && !full_w;
  assign rd_acc = fifo.re && !empty_w;

  always_comb begin
    out_load = 1'b0;
    ram_rd   = 1'b0;
    if (FWFT != 0) begin
      out_load = ram_q_valid && (!out_valid || rd_acc);
      ram_rd   = !ram_empty && (!ram_q_valid || out_load);
    end else begin
      ram_rd   = rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= fifo.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (FWFT != 0 && ram_rd) begin
      ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      dout_q      <= '0;
      ram_q_valid <= 1'b0;
      out_valid   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase

      // A new error in the same cycle as clear_err keeps the flag set.
      if (fifo.we && full_w) begin
        ovf_q <= 1'b1;
      end else if (fifo.clear_err) begin
        ovf_q <= 1'b0;
      end
      if (fifo.re && empty_w) begin
        unf_q <= 1'b1;
      end else if (fifo.clear_err) begin
        unf_q <= 1'b0;
      end

      if (FWFT != 0) begin
        if (ram_rd) begin
          ram_q_valid <= 1'b1;
        end else if (out_load) begin
          ram_q_valid <= 1'b0;
        end
        if (out_load) begin
          out_valid <= 1'b1;
          dout_q    <= ram_q;
        end else if (rd_acc) begin
          out_valid <= 1'b0;
        end
      end else if (ram_rd) begin
        dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign fifo.full         = full_w;
  assign fifo.empty        = empty_w;
  assign fifo.level        = level_q;
  assign fifo.almost_full  = (level_q >= AFULL_LV);
  assign fifo.almost_empty = (level_q <= AEMPTY_LV);
  assign fifo.data_out     = dout_q;
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule
